// File: rtl/sd_fifo_pkg.sv
// sd_fifo_pkg: shared constants for the SD-side FIFO client.
// Channel map, flag index rule and default byte width.
`timescale 1ns/1ps
package sd_fifo_pkg;

  localparam int SD_DAT_WIDTH = 8;
  localparam int SD_N_CH = 4;

  typedef enum logic [1:0] {
    CH_TX  = 2'd0,
    CH_RX  = 2'd1,
    CH_CMD = 2'd2,
    CH_RSP = 2'd3
  } ch_e;

  // FIFO flag vectors are declared [1:4].
  function automatic int flag_idx(input ch_e ch);
    return int'(ch) + 1;
  endfunction

endpackage

// File: rtl/sd_fifo_if.sv
// sd_fifo_if: SD-side port of the shared FIFO.
// master = client (drives adr/re/we/dat), slave = FIFO.
`timescale 1ns/1ps
interface sd_fifo_if
  import sd_fifo_pkg::*;
#(
  parameter int DW = SD_DAT_WIDTH
);
  logic [1:0]    fifo_adr_o;
  logic          fifo_re_o;
  logic          fifo_we_o;
  logic [DW-1:0] fifo_dat_o;
  logic [DW-1:0] fifo_dat_i;
  logic [1:4]    fifo_full_i;
  logic [1:4]    fifo_empty_i;

  modport master (
    output fifo_adr_o, fifo_re_o,
    output fifo_we_o, fifo_dat_o,
    input  fifo_dat_i,
    input  fifo_full_i, fifo_empty_i
  );

  modport slave (
    input  fifo_adr_o, fifo_re_o,
    input  fifo_we_o, fifo_dat_o,
    output fifo_dat_i,
    output fifo_full_i, fifo_empty_i
  );
endinterface

// File: rtl/sd_fifo_rd_buf.sv
// sd_fifo_rd_buf: FWFT prefetch buffer for one read channel.
// issue=read granted, rd_dat=RAM data (next cycle), valid/dat/ready=stream, space=may issue.
`timescale 1ns/1ps
module sd_fifo_rd_buf
  import sd_fifo_pkg::*;
#(
  parameter int DW    = SD_DAT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic [DW-1:0] rd_dat,
  output logic          valid,
  output logic [DW-1:0] dat,
  input  logic          ready,
  output logic          space
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic [AW+1:0] occ;
  logic          inflight;
  logic          pop;

  assign valid = cnt != '0;
  assign dat   = mem[rp];
  assign pop   = valid & ready;

  // Registered occupancy only: a pop this
  // cycle never frees space for this cycle.
  assign occ = {1'b0, cnt}
             + {{(AW+1){1'b0}}, inflight};
  assign space = occ < (AW+2)'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (inflight) wp <= wp + 1'b1;
      if (pop)      rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, inflight}
                 - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) mem[wp] <= rd_dat;
  end

endmodule

// File: rtl/sd_fifo_client.sv
// sd_fifo_client: splits the FIFO SD port into tx/cmd sources
// and rx/rsp sinks; round-robin, one access per cycle.
`timescale 1ns/1ps
module sd_fifo_client
  import sd_fifo_pkg::*;
#(
  parameter int DAT_WIDTH    = 8,
  parameter int RD_BUF_DEPTH = 2
) (
  input  logic                 sd_clk,
  input  logic                 rst_n,
  sd_fifo_if.master            fifo,
  output logic [DAT_WIDTH-1:0] tx_dat_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [DAT_WIDTH-1:0] cmd_dat_o,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  input  logic [DAT_WIDTH-1:0] rx_dat_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  input  logic [DAT_WIDTH-1:0] rsp_dat_i,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o
);
  logic                 tx_space, cmd_space;
  logic                 tx_issue, cmd_issue;
  logic [DAT_WIDTH-1:0] rx_hold, rsp_hold;
  logic                 rx_full, rsp_full;
  logic [1:0]           ptr, adr_q, gnt, c;
  logic                 gnt_v, wr_rx, wr_rsp;
  logic [3:0]           req;
  logic                 unused_flags;

  assign unused_flags = ^{fifo.fifo_full_i[1],
                          fifo.fifo_full_i[3],
                          fifo.fifo_empty_i[2],
                          fifo.fifo_empty_i[4]};

  // Flags are current, not registered, so a
  // request never sees a stale empty/full.
  always_comb begin
    req = '0;
    if (rst_n) begin
      req[CH_TX]  = !fifo.fifo_empty_i[flag_idx(CH_TX)]
                  && tx_space;
      req[CH_RX]  = rx_full
                  && !fifo.fifo_full_i[flag_idx(CH_RX)];
      req[CH_CMD] = !fifo.fifo_empty_i[flag_idx(CH_CMD)]
                  && cmd_space;
      req[CH_RSP] = rsp_full
                  && !fifo.fifo_full_i[flag_idx(CH_RSP)];
    end
  end

  // Scan downwards so the smallest offset
  // from ptr is the last (winning) write.
  always_comb begin
    gnt   = ptr;
    gnt_v = 1'b0;
    c     = '0;
    for (int i = 3; i >= 0; i--) begin
      c = ptr + 2'(i);
      if (req[c]) begin
        gnt   = c;
        gnt_v = 1'b1;
      end
    end
  end

  assign fifo.fifo_re_o = gnt_v & ~gnt[0];
  assign fifo.fifo_we_o = gnt_v &  gnt[0];
  assign fifo.fifo_adr_o = gnt_v ? gnt : adr_q;

  assign tx_issue  = fifo.fifo_re_o && gnt == CH_TX;
  assign cmd_issue = fifo.fifo_re_o && gnt == CH_CMD;
  assign wr_rx     = fifo.fifo_we_o && gnt == CH_RX;
  assign wr_rsp    = fifo.fifo_we_o && gnt == CH_RSP;

  always_comb begin
    unique case (1'b1)
      wr_rx:   fifo.fifo_dat_o = rx_hold;
      wr_rsp:  fifo.fifo_dat_o = rsp_hold;
      default: fifo.fifo_dat_o = '0;
    endcase
  end

  assign rx_ready_o  = !rx_full;
  assign rsp_ready_o = !rsp_full;

  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      adr_q    <= '0;
      rx_full  <= 1'b0;
      rsp_full <= 1'b0;
      rx_hold  <= '0;
      rsp_hold <= '0;
    end else begin
      if (gnt_v) begin
        ptr   <= gnt + 2'd1;
        adr_q <= gnt;
      end
      // Load and commit never coincide:
      // ready is low while the hold is full.
      if (rx_valid_i && rx_ready_o) begin
        rx_full <= 1'b1;
        rx_hold <= rx_dat_i;
      end else if (wr_rx) begin
        rx_full <= 1'b0;
      end
      if (rsp_valid_i && rsp_ready_o) begin
        rsp_full <= 1'b1;
        rsp_hold <= rsp_dat_i;
      end else if (wr_rsp) begin
        rsp_full <= 1'b0;
      end
    end
  end

  sd_fifo_rd_buf #(
    .DW(DAT_WIDTH), .DEPTH(RD_BUF_DEPTH)
  ) u_tx_buf (
    .clk(sd_clk), .rst_n(rst_n),
    .issue(tx_issue), .rd_dat(fifo.fifo_dat_i),
    .valid(tx_valid_o), .dat(tx_dat_o),
    .ready(tx_ready_i), .space(tx_space)
  );

  sd_fifo_rd_buf #(
    .DW(DAT_WIDTH), .DEPTH(RD_BUF_DEPTH)
  ) u_cmd_buf (
    .clk(sd_clk), .rst_n(rst_n),
    .issue(cmd_issue), .rd_dat(fifo.fifo_dat_i),
    .valid(cmd_valid_o), .dat(cmd_dat_o),
    .ready(cmd_ready_i), .space(cmd_space)
  );

endmodule

// File: tb/tb_sd_fifo_client.sv
// tb_sd_fifo_client: directed bench with a small FIFO model
// (per-channel queues, registered read data, live flags).
`timescale 1ns/1ps
module tb_sd_fifo_client;
  import sd_fifo_pkg::*;

  logic sd_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sd_clk = ~sd_clk;

  sd_fifo_if #(.DW(8)) fifo ();

  logic [7:0] tx_dat_o, cmd_dat_o;
  logic       tx_valid_o, cmd_valid_o;
  logic       tx_ready_i = 1'b0, cmd_ready_i = 1'b0;
  logic [7:0] rx_dat_i = 8'h00, rsp_dat_i = 8'h00;
  logic       rx_valid_i = 1'b0, rsp_valid_i = 1'b0;
  logic       rx_ready_o, rsp_ready_o;
  logic       full_rx = 1'b0, full_rsp = 1'b0;

  // FIFO model state
  logic [7:0] q [4][$];
  logic [1:4] m_empty = 4'b1111;
  logic [7:0] m_rd = 8'h00;
  logic       ld_go = 1'b0;
  logic [1:0] ld_ch = 2'd0;
  int         ld_n = 0;
  logic [7:0] ld_b [16];
  logic       s_re = 1'b0, s_we = 1'b0;
  logic [1:0] s_adr = 2'd0;
  logic [7:0] s_dat = 8'h00;
  int         cyc = 0;
  int         illegal = 0;
  int         g_adr [$];
  int         g_cyc [$];
  logic [7:0] tx_log [$];
  logic [7:0] cmd_log [$];

  int n_tests = 0;
  int n_fail  = 0;

  assign fifo.fifo_full_i  = {1'b0, full_rx, 1'b0, full_rsp};
  assign fifo.fifo_empty_i = m_empty;
  assign fifo.fifo_dat_i   = m_rd;

  sd_fifo_client #(.DAT_WIDTH(8), .RD_BUF_DEPTH(2)) dut (
    .sd_clk(sd_clk), .rst_n(rst_n), .fifo(fifo),
    .tx_dat_o(tx_dat_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .cmd_dat_o(cmd_dat_o), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i),
    .rx_dat_i(rx_dat_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .rsp_dat_i(rsp_dat_i), .rsp_valid_i(rsp_valid_i),
    .rsp_ready_o(rsp_ready_o)
  );

  // Sample the access the DUT presents for the next edge.
  always @(negedge sd_clk) begin
    cyc   <= cyc + 1;
    s_re  <= fifo.fifo_re_o;
    s_we  <= fifo.fifo_we_o;
    s_adr <= fifo.fifo_adr_o;
    s_dat <= fifo.fifo_dat_o;
    illegal <= illegal
      + int'(fifo.fifo_re_o && fifo.fifo_we_o)
      + int'(fifo.fifo_re_o
             && m_empty[int'(fifo.fifo_adr_o) + 1])
      + int'(fifo.fifo_we_o
             && fifo.fifo_full_i[int'(fifo.fifo_adr_o) + 1]);
    if (fifo.fifo_re_o || fifo.fifo_we_o) begin
      g_adr.push_back(int'(fifo.fifo_adr_o));
      g_cyc.push_back(cyc);
    end
    if (tx_valid_o && tx_ready_i) tx_log.push_back(tx_dat_o);
    if (cmd_valid_o && cmd_ready_i) cmd_log.push_back(cmd_dat_o);
  end

  always @(posedge sd_clk) begin
    if (ld_go)
      for (int i = 0; i < ld_n; i++) q[ld_ch].push_back(ld_b[i]);
    if (s_re) begin
      if (q[s_adr].size() > 0) m_rd <= q[s_adr].pop_front();
      else m_rd <= 8'hEE;
    end
    if (s_we) q[s_adr].push_back(s_dat);
    for (int k = 0; k < 4; k++) m_empty[k+1] <= (q[k].size() == 0);
  end

  task automatic nx();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic ng();
    @(negedge sd_clk);
  endtask

  // Model loads the bytes on the next edge; returns 1ns after it.
  task automatic load(input logic [1:0] ch, input int n);
    ld_ch = ch;
    ld_n  = n;
    ld_go = 1'b1;
    nx();
    ld_go = 1'b0;
  endtask

  task automatic test_reset();
    int g0;
    repeat (3) ng();
    n_tests++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid_o); end
    n_tests++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid_o); end
    n_tests++; if (rx_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready got %b want 1", rx_ready_o); end
    n_tests++; if (rsp_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_rsp_ready got %b want 1", rsp_ready_o); end
    n_tests++; if ({fifo.fifo_re_o, fifo.fifo_we_o} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {fifo.fifo_re_o, fifo.fifo_we_o}); end
    n_tests++; if (fifo.fifo_adr_o !== 2'd0) begin n_fail++; $display("FAIL reset_adr got %0d want 0", fifo.fifo_adr_o); end
    n_tests++; if (fifo.fifo_dat_o !== 8'h00) begin n_fail++; $display("FAIL reset_dat got %h want 00", fifo.fifo_dat_o); end
    nx();
    rst_n = 1'b1;
    g0 = g_adr.size();
    repeat (20) ng();
    n_tests++; if (g_adr.size() - g0 !== 0) begin n_fail++; $display("FAIL idle_strobes got %0d want 0", g_adr.size() - g0); end
    n_tests++; if ({tx_valid_o, cmd_valid_o} !== 2'b00) begin n_fail++; $display("FAIL idle_valids got %b want 00", {tx_valid_o, cmd_valid_o}); end
  endtask

  task automatic test_tx_stream();
    logic [7:0] e [3];
    int g0, t0, bad;
    e = '{8'h11, 8'h22, 8'h33};
    nx();
    tx_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) ld_b[i] = e[i];
    g0 = g_adr.size();
    t0 = tx_log.size();
    load(2'd0, 3);
    ng();
    n_tests++; if ({fifo.fifo_re_o, fifo.fifo_adr_o} !== 3'b100) begin n_fail++; $display("FAIL tx_first_read got re=%b adr=%0d want re=1 adr=0", fifo.fifo_re_o, fifo.fifo_adr_o); end
    n_tests++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL tx_valid_c0 got %b want 0", tx_valid_o); end
    nx(); ng();
    n_tests++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL tx_valid_c1 got %b want 0", tx_valid_o); end
    nx(); ng();
    n_tests++; if ({tx_valid_o, tx_dat_o} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL tx_first_byte got v=%b d=%h want v=1 d=11", tx_valid_o, tx_dat_o); end
    repeat (8) ng();
    n_tests++; if (tx_log.size() - t0 !== 3) begin n_fail++; $display("FAIL tx_count got %0d want 3", tx_log.size() - t0); end
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (t0 + i < tx_log.size() && tx_log[t0+i] !== e[i]) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL tx_order got %0d wrong bytes want 0", bad); end
    bad = 0;
    for (int i = g0; i < g_adr.size(); i++) if (g_adr[i] != 0) bad++;
    n_tests++; if (g_adr.size() - g0 !== 3 || bad !== 0) begin n_fail++; $display("FAIL tx_reads got %0d (%0d off ch0) want 3 (0)", g_adr.size() - g0, bad); end
  endtask

  task automatic test_tx_backpressure();
    int g0, t0, bad;
    nx();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) ld_b[i] = 8'(8'h51 + i);
    g0 = g_adr.size();
    load(2'd0, 5);
    repeat (10) ng();
    n_tests++; if (g_adr.size() - g0 !== 2) begin n_fail++; $display("FAIL bp_reads got %0d want 2", g_adr.size() - g0); end
    n_tests++; if ({tx_valid_o, tx_dat_o} !== {1'b1, 8'h51}) begin n_fail++; $display("FAIL bp_head got v=%b d=%h want v=1 d=51", tx_valid_o, tx_dat_o); end
    n_tests++; if (q[0].size() !== 3) begin n_fail++; $display("FAIL bp_fifo_left got %0d want 3", q[0].size()); end
    t0 = tx_log.size();
    nx();
    tx_ready_i = 1'b1;
    repeat (20) ng();
    n_tests++; if (tx_log.size() - t0 !== 5) begin n_fail++; $display("FAIL bp_drain_count got %0d want 5", tx_log.size() - t0); end
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (t0 + i < tx_log.size() && tx_log[t0+i] !== 8'(8'h51 + i)) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bp_drain_order got %0d wrong want 0", bad); end
    n_tests++; if (g_adr.size() - g0 !== 5) begin n_fail++; $display("FAIL bp_total_reads got %0d want 5", g_adr.size() - g0); end
  endtask

  task automatic test_rx_backpressure();
    int g0, qs, sent, bp, bad;
    g0 = g_adr.size();
    qs = q[1].size();
    sent = 0;
    bp = 0;
    for (int c = 0; c < 60 && sent < 8; c++) begin
      nx();
      if (c == 3)  full_rx = 1'b1;
      if (c == 11) full_rx = 1'b0;
      rx_valid_i = 1'b1;
      rx_dat_i   = 8'(8'hA0 + sent);
      ng();
      if (!rx_ready_o && full_rx) bp++;
      if (rx_ready_o) sent++;
    end
    nx();
    rx_valid_i = 1'b0;
    full_rx = 1'b0;
    repeat (10) ng();
    n_tests++; if (sent !== 8) begin n_fail++; $display("FAIL rx_accepted got %0d want 8", sent); end
    n_tests++; if (bp == 0) begin n_fail++; $display("FAIL rx_backpressure got %0d stalled cycles want >0", bp); end
    n_tests++; if (q[1].size() - qs !== 8) begin n_fail++; $display("FAIL rx_written got %0d want 8", q[1].size() - qs); end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (qs + i < q[1].size() && q[1][qs+i] !== 8'(8'hA0 + i)) bad++;
    for (int i = g0; i < g_adr.size(); i++) if (g_adr[i] != 1) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rx_order_adr got %0d wrong want 0", bad); end
  endtask

  task automatic test_round_robin();
    int g0, bad, gap;
    nx();
    tx_ready_i  = 1'b1;
    cmd_ready_i = 1'b1;
    rx_valid_i  = 1'b1;
    rx_dat_i    = 8'h3C;
    rsp_valid_i = 1'b1;
    rsp_dat_i   = 8'h5A;
    for (int i = 0; i < 12; i++) ld_b[i] = 8'(8'h80 + i);
    load(2'd0, 12);
    load(2'd2, 12);
    repeat (8) ng();
    g0 = g_adr.size();
    repeat (12) ng();
    n_tests++; if (g_adr.size() - g0 !== 12) begin n_fail++; $display("FAIL rr_grants got %0d want 12", g_adr.size() - g0); end
    bad = 0;
    gap = 0;
    for (int i = g0; i + 1 < g_adr.size(); i++) begin
      if (g_adr[i+1] != (g_adr[i] + 1) % 4) bad++;
      if (g_cyc[i+1] - g_cyc[i] != 1) gap++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rr_rotation got %0d bad steps want 0", bad); end
    n_tests++; if (gap !== 0) begin n_fail++; $display("FAIL rr_idle_gaps got %0d want 0", gap); end
    nx();
    rx_valid_i  = 1'b0;
    rsp_valid_i = 1'b0;
    repeat (40) ng();
    n_tests++; if (q[0].size() + q[2].size() !== 0) begin n_fail++; $display("FAIL rr_drain got %0d left want 0", q[0].size() + q[2].size()); end
    n_tests++; if ({tx_valid_o, cmd_valid_o, rx_ready_o, rsp_ready_o} !== 4'b0011) begin n_fail++; $display("FAIL rr_idle got %b want 0011", {tx_valid_o, cmd_valid_o, rx_ready_o, rsp_ready_o}); end
  endtask

  task automatic test_reset_inflight();
    nx();
    cmd_ready_i = 1'b0;
    tx_ready_i  = 1'b0;
    ld_b[0] = 8'hC1;
    ld_b[1] = 8'hC2;
    ld_b[2] = 8'hC3;
    load(2'd2, 3);
    nx();
    nx();
    ng();
    n_tests++; if ({cmd_valid_o, cmd_dat_o} !== {1'b1, 8'hC1}) begin n_fail++; $display("FAIL rst_pre got v=%b d=%h want v=1 d=c1", cmd_valid_o, cmd_dat_o); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if ({cmd_valid_o, fifo.fifo_re_o} !== 2'b00) begin n_fail++; $display("FAIL rst_async got v=%b re=%b want 00", cmd_valid_o, fifo.fifo_re_o); end
    nx();
    rst_n = 1'b1;
    ng();
    n_tests++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_release got %b want 0", cmd_valid_o); end
    nx(); ng();
    n_tests++; if (cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_stale got %b want 0", cmd_valid_o); end
    nx(); ng();
    n_tests++; if ({cmd_valid_o, cmd_dat_o} !== {1'b1, 8'hC3}) begin n_fail++; $display("FAIL rst_next_byte got v=%b d=%h want v=1 d=c3", cmd_valid_o, cmd_dat_o); end
    n_tests++; if (q[2].size() !== 0) begin n_fail++; $display("FAIL rst_fifo_left got %0d want 0", q[2].size()); end
  endtask

  initial begin
    test_reset();
    test_tx_stream();
    test_tx_backpressure();
    test_rx_backpressure();
    test_round_robin();
    test_reset_inflight();
    repeat (2) ng();
    n_tests++; if (illegal !== 0) begin n_fail++; $display("FAIL strobe_legality got %0d bad strobes want 0", illegal); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_fifo_client.md
Name: sd_fifo_client

Overview:
- SD-clock-domain client for the 4-channel SD-side port of the shared dual-port FIFO block.
- Channel map:
  - ch0 is wb->sd data.
  - ch1 is sd->wb data.
  - ch2 is wb->sd command.
  - ch3 is sd->wb response.
- Converts the FIFO's single address-multiplexed port into four valid/ready byte streams for the SD data and command engines.
- Arbitrates one FIFO access per cycle and hides the one-cycle RAM read latency with per-channel prefetch buffers.

Parameters:
- DAT_WIDTH, 8, byte width on all data paths; must match the FIFO RAM width.
- RD_BUF_DEPTH, 2, prefetch entries per read channel (ch0, ch2); power of two, >= 2.

Ports:
- sd_clk  in  1  SD-side clock, same clock as the FIFO's SD port.
- rst_n  in  1  asynchronous active-low reset.
- fifo_adr_o  out  2  channel select to the FIFO SD port.
- fifo_re_o  out  1  read strobe for ch0/ch2.
- fifo_we_o  out  1  write strobe for ch1/ch3.
- fifo_dat_o  out  DAT_WIDTH  write data to the FIFO.
- fifo_dat_i  in  DAT_WIDTH  registered RAM read data, valid the cycle after fifo_re_o.
- fifo_full_i  in  [1:4]  FIFO full flags, index = channel+1.
- fifo_empty_i  in  [1:4]  FIFO empty flags, index = channel+1.
- tx_dat_o / tx_valid_o / tx_ready_i  out/out/in  DAT_WIDTH/1/1  ch0 source stream.
- cmd_dat_o / cmd_valid_o / cmd_ready_i  out/out/in  DAT_WIDTH/1/1  ch2 source stream.
- rx_dat_i / rx_valid_i / rx_ready_o  in/in/out  DAT_WIDTH/1/1  ch1 sink stream.
- rsp_dat_i / rsp_valid_i / rsp_ready_o  in/in/out  DAT_WIDTH/1/1  ch3 sink stream.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All buffers empty, all holding registers empty, in-flight flags cleared, arbiter pointer = ch0.
  - All *_valid_o = 0; rx_ready_o = rsp_ready_o = 1.
  - fifo_re_o = fifo_we_o = 0, fifo_adr_o = 0, fifo_dat_o = 0.
- Stream handshakes: transfer occurs when valid & ready at the sd_clk edge. Source data is held stable while valid & !ready.
- Read channels (ch0, ch2):
  - Each has an RD_BUF_DEPTH FIFO buffer plus an in-flight bit.
  - Request when fifo_empty_i[ch+1]=0 and occupancy + inflight < RD_BUF_DEPTH.
- Write channels (ch1, ch3):
  - Each has a 1-entry holding register; ready_o = holding empty.
  - Request when holding full and fifo_full_i[ch+1]=0.
- Arbiter:
  - Round-robin over the 4 requests, starting at the pointer.
  - On a grant, the pointer moves to grant+1 (mod 4).
  - At most one of fifo_re_o/fifo_we_o is asserted per cycle.
  - Strobes, fifo_adr_o and fifo_dat_o are combinational from registered state and the current flags. This is required so no access is issued against a stale empty/full flag.
  - With no request: strobes 0, fifo_adr_o holds its last value.
- Read latency:
  - Granting a read at edge N sets inflight for ch.
  - At edge N+1, fifo_dat_i is pushed into that channel's buffer and inflight clears.
  - Back-to-back reads of the same channel are allowed only if buffer space permits.
- Source output: valid_o = buffer non-empty; dat_o = head entry (first-word-fall-through). Byte order is preserved per channel.
- Write commit: at a granted write edge the holding register empties. The same edge may refill it if valid_i & ready_o was sampled that cycle; the ready_o seen that cycle was 0, so refill takes effect the next cycle. Net throughput is 1 byte per 2 cycles per write channel when not contended.
- Simultaneous events:
  - A buffer push and pop in the same cycle leave occupancy unchanged.
  - A full buffer that pops in a cycle does not enable a read grant that same cycle; space is computed from registered occupancy.
- Empty/full boundary:
  - Flags asserting on the access edge are honoured because the FIFO gates its pointers with the same flags.
  - A strobe issued with the flag set is illegal and is flagged by bench assertion.
- Reset mid-operation:
  - Buffered and in-flight bytes are discarded.
  - rst_n shall be asserted together with the FIFO reset; a standalone client reset loses data already popped.

Decomposition:
- Shared package sd_fifo_pkg:
  - Channel constants CH_TX=0, CH_RX=1, CH_CMD=2, CH_RSP=3.
  - The flag index rule (ch+1).
  - DAT_WIDTH default.
- Sub-module sd_fifo_rd_buf: parameterised FWFT buffer with inflight tracking and space output. Instantiated for ch0 and ch2.

Test Plan:
- Reset, with fifo_empty_i=4'b1111 and fifo_full_i=0 -> all valid_o=0, both ready_o=1, no strobes for 20 cycles.
- Preload ch0 with 0x11,0x22,0x33, tx_ready_i=1 -> fifo_re_o pulses with adr=0, tx_dat_o sequence 0x11,0x22,0x33, first byte valid 2 cycles after empty deasserts.
- tx_ready_i=0 with ch0 holding 5 bytes -> exactly RD_BUF_DEPTH=2 reads issued, then none; releasing ready drains 0x..in order with no loss or duplicates.
- rx_valid_i streaming 0xA0..0xA7 with fifo_full_i[2]=1 for cycles 3-10 -> no fifo_we_o while full, rx_ready_o=0 backpressure, all 8 bytes written with adr=1 in order.
- All four channels requesting continuously -> grants rotate 0,1,2,3,0..., no channel starved for more than 4 cycles, never re & we in the same cycle.
- Assert rst_n=0 with an in-flight ch2 read -> cmd_valid_o drops immediately, and the late fifo_dat_i is not pushed after reset releases.
